// File: rtl/alu_control_seq_if.sv
// ID/EX ALU-control bundle: instruction handshake from ID, decoded controls
// and mult/div sequencing signals toward EX and the hazard unit.
interface alu_control_seq_if #(
  parameter int ALUOP_W = 2,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 4
);
  logic               valid_in;
  logic [ALUOP_W-1:0] aluop;
  logic [FUNCT_W-1:0] funct;
  logic               flush;
  logic [CTRL_W-1:0]  alucontrol;
  logic               jr;
  logic               valid_out;
  logic               illegal;
  logic               stall;
  logic               md_start;
  logic               md_is_div;
  logic               md_done;

  modport master (
    output valid_in, aluop, funct, flush,
    input  alucontrol, jr, valid_out, illegal, stall, md_start, md_is_div, md_done
  );

  modport slave (
    input  valid_in, aluop, funct, flush,
    output alucontrol, jr, valid_out, illegal, stall, md_start, md_is_div, md_done
  );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU-control decode at the ID/EX boundary with a MULT/DIV busy
// sequencer that stalls upstream while the external mult/div unit runs.
module alu_control_seq #(
  parameter int ALUOP_W   = 2,
  parameter int FUNCT_W   = 6,
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_control_seq_if.slave bus
);

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;

  localparam logic [FUNCT_W-1:0] FN_ADD  = FUNCT_W'(32);
  localparam logic [FUNCT_W-1:0] FN_SUB  = FUNCT_W'(34);
  localparam logic [FUNCT_W-1:0] FN_AND  = FUNCT_W'(36);
  localparam logic [FUNCT_W-1:0] FN_OR   = FUNCT_W'(37);
  localparam logic [FUNCT_W-1:0] FN_NOR  = FUNCT_W'(39);
  localparam logic [FUNCT_W-1:0] FN_SLT  = FUNCT_W'(42);
  localparam logic [FUNCT_W-1:0] FN_SLL  = FUNCT_W'(0);
  localparam logic [FUNCT_W-1:0] FN_JR   = FUNCT_W'(8);
  localparam logic [FUNCT_W-1:0] FN_MULT = FUNCT_W'(24);
  localparam logic [FUNCT_W-1:0] FN_DIV  = FUNCT_W'(26);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_CYCLES - 1);

  typedef struct packed {
    logic [3:0] op;
    logic       jr;
    logic       illegal;
    logic       is_md;
    logic       is_div;
  } dec_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  // R-format funct decode; unknown functs fall back to ADD and flag illegal.
  function automatic dec_t decode_funct(input logic [FUNCT_W-1:0] fn);
    dec_t d;
    d = '{op: OP_ADD, jr: 1'b0, illegal: 1'b0, is_md: 1'b0, is_div: 1'b0};
    case (fn)
      FN_ADD:  d.op = OP_ADD;
      FN_SUB:  d.op = OP_SUB;
      FN_AND:  d.op = OP_AND;
      FN_OR:   d.op = OP_OR;
      FN_NOR:  d.op = OP_NOR;
      FN_SLT:  d.op = OP_SLT;
      FN_SLL:  d.op = OP_SLL;
      FN_JR:   d.jr = 1'b1;
      FN_MULT: begin
        d.op    = OP_MULT;
        d.is_md = 1'b1;
      end
      FN_DIV:  begin
        d.op     = OP_DIV;
        d.is_md  = 1'b1;
        d.is_div = 1'b1;
      end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // Narrow aluop is zero-extended, so the immediate OR/SLT codes are unreachable at width 2.
  function automatic dec_t decode(input logic [ALUOP_W-1:0] aluop,
                                  input logic [FUNCT_W-1:0] fn);
    dec_t       d;
    logic [2:0] op3;
    d   = '{op: OP_ADD, jr: 1'b0, illegal: 1'b0, is_md: 1'b0, is_div: 1'b0};
    op3 = 3'(aluop);
    case (op3)
      3'd0:    d.op = OP_ADD;
      3'd1:    d.op = OP_SUB;
      3'd2:    d = decode_funct(fn);
      3'd3:    d.op = OP_AND;
      3'd4:    d.op = OP_OR;
      3'd5:    d.op = OP_SLT;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [CTRL_W-1:0] alucontrol_r, alucontrol_s;
  logic              jr_r, jr_s;
  logic              valid_out_r, valid_out_s;
  logic              illegal_r, illegal_s;
  logic              stall_r, stall_s;
  logic              md_start_r, md_start_s;
  logic              md_is_div_r, md_is_div_s;
  logic              md_done_r, md_done_s;
  dec_t              dec_s;
  logic              accept_s;

  assign dec_s    = decode(bus.aluop, bus.funct);
  assign accept_s = bus.valid_in & ~stall_r & ~bus.flush;

  // Next-state and next-output logic for decode and the mult/div sequencer.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    alucontrol_s = alucontrol_r;
    jr_s         = 1'b0;
    valid_out_s  = 1'b0;
    illegal_s    = 1'b0;
    stall_s      = 1'b0;
    md_start_s   = 1'b0;
    md_is_div_s  = 1'b0;
    md_done_s    = 1'b0;

    if (accept_s) begin
      valid_out_s  = 1'b1;
      alucontrol_s = CTRL_W'(dec_s.op);
      jr_s         = dec_s.jr;
      illegal_s    = dec_s.illegal;
    end else begin
      valid_out_s  = 1'b0;
    end

    case (state_r)
      // DONE accepts like IDLE, so a back-to-back MULT/DIV goes straight to BUSY.
      IDLE, DONE: begin
        if (accept_s && dec_s.is_md) begin
          state_s     = BUSY;
          cnt_s       = CNT_LOAD;
          stall_s     = 1'b1;
          md_start_s  = 1'b1;
          md_is_div_s = dec_s.is_div;
        end else begin
          state_s     = IDLE;
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_s = IDLE;
          cnt_s   = CNT_ZERO;
        end else if (cnt_r == CNT_ZERO) begin
          state_s   = DONE;
          md_done_s = 1'b1;
        end else begin
          cnt_s   = cnt_r - CNT_ONE;
          stall_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      alucontrol_r <= {CTRL_W{1'b0}};
      jr_r         <= 1'b0;
      valid_out_r  <= 1'b0;
      illegal_r    <= 1'b0;
      stall_r      <= 1'b0;
      md_start_r   <= 1'b0;
      md_is_div_r  <= 1'b0;
      md_done_r    <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      alucontrol_r <= alucontrol_s;
      jr_r         <= jr_s;
      valid_out_r  <= valid_out_s;
      illegal_r    <= illegal_s;
      stall_r      <= stall_s;
      md_start_r   <= md_start_s;
      md_is_div_r  <= md_is_div_s;
      md_done_r    <= md_done_s;
    end
  end

  assign bus.alucontrol = alucontrol_r;
  assign bus.jr         = jr_r;
  assign bus.valid_out  = valid_out_r;
  assign bus.illegal    = illegal_r;
  assign bus.stall      = stall_r;
  assign bus.md_start   = md_start_r;
  assign bus.md_is_div  = md_is_div_r;
  assign bus.md_done    = md_done_r;

endmodule

// File: tb/tb_alu_control_seq.sv
// Directed and randomized checks of alu_control_seq against a cycle-level
// behavioural model built from the decode tables and busy-cycle count.
module tb_alu_control_seq;

  localparam int MDC = 4;

  logic clk;
  logic reset_n;
  int   nchk;
  int   errs;

  alu_control_seq_if #(.ALUOP_W(3), .FUNCT_W(6), .CTRL_W(4)) bus ();

  alu_control_seq #(
    .ALUOP_W(3), .FUNCT_W(6), .CTRL_W(4), .MD_CYCLES(MDC), .CNT_W(3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model state: busy flag plus BUSY cycles still to run, and expected outputs.
  bit m_busy;
  int m_left;
  int e_ctrl;
  bit e_jr, e_valid, e_ill, e_stall, e_start, e_isdiv, e_done;

  int ftab[10] = '{32, 34, 36, 37, 39, 42, 0, 8, 24, 26};
  int t2f[7]   = '{32, 34, 36, 37, 39, 42, 0};
  int t2e[7]   = '{2, 6, 0, 1, 12, 7, 3};

  task automatic ref_decode(input int op, input int fn, output int ctrl, output bit jr,
                            output bit ill, output bit md, output bit div);
    ctrl = 2; jr = 1'b0; ill = 1'b0; md = 1'b0; div = 1'b0;
    case (op)
      0: ctrl = 2;
      1: ctrl = 6;
      3: ctrl = 0;
      4: ctrl = 1;
      5: ctrl = 7;
      2: begin
        case (fn)
          32: ctrl = 2;
          34: ctrl = 6;
          36: ctrl = 0;
          37: ctrl = 1;
          39: ctrl = 12;
          42: ctrl = 7;
          0:  ctrl = 3;
          8:  jr = 1'b1;
          24: begin ctrl = 8; md = 1'b1; end
          26: begin ctrl = 9; md = 1'b1; div = 1'b1; end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_left = 0; e_ctrl = 0;
    e_jr = 1'b0; e_valid = 1'b0; e_ill = 1'b0; e_stall = 1'b0;
    e_start = 1'b0; e_isdiv = 1'b0; e_done = 1'b0;
  endtask

  task automatic model_edge(input bit v, input int op, input int fn, input bit fl);
    int ctrl; bit jr, ill, md, div, acc;
    acc = v && !m_busy && !fl;
    e_valid = 1'b0; e_jr = 1'b0; e_ill = 1'b0;
    e_start = 1'b0; e_isdiv = 1'b0; e_done = 1'b0;
    if (m_busy) begin
      if (fl) m_busy = 1'b0;
      else begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_busy = 1'b0; e_done = 1'b1; end
      end
    end else if (acc) begin
      ref_decode(op, fn, ctrl, jr, ill, md, div);
      e_valid = 1'b1; e_ctrl = ctrl; e_jr = jr; e_ill = ill;
      if (md) begin m_busy = 1'b1; m_left = MDC; e_start = 1'b1; e_isdiv = div; end
    end
    e_stall = m_busy;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".alucontrol"}, 8'(bus.alucontrol), 8'(e_ctrl));
    chk({tag, ".jr"},         8'(bus.jr),         8'(e_jr));
    chk({tag, ".valid_out"},  8'(bus.valid_out),  8'(e_valid));
    chk({tag, ".illegal"},    8'(bus.illegal),    8'(e_ill));
    chk({tag, ".stall"},      8'(bus.stall),      8'(e_stall));
    chk({tag, ".md_start"},   8'(bus.md_start),   8'(e_start));
    chk({tag, ".md_is_div"},  8'(bus.md_is_div),  8'(e_isdiv));
    chk({tag, ".md_done"},    8'(bus.md_done),    8'(e_done));
  endtask

  // Inputs change at the falling edge; outputs are checked at the next falling edge.
  task automatic step(input string tag, input bit v, input int op, input int fn, input bit fl);
    bus.valid_in = v; bus.aluop = 3'(op); bus.funct = 6'(fn); bus.flush = fl;
    @(posedge clk);
    model_edge(v, op & 7, fn & 63, fl);
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int op, fn;
    bit v, fl;
    nchk = 0; errs = 0;
    clk = 1'b0; reset_n = 1'b0;
    bus.valid_in = 1'b0; bus.aluop = 3'd0; bus.funct = 6'd0; bus.flush = 1'b0;
    model_reset();
    @(negedge clk);
    check_all("reset");
    reset_n = 1'b1;

    // T1: immediate op classes
    step("t1_add", 1'b1, 0, 0, 1'b0);  chk("t1_add_ctrl", 8'(bus.alucontrol), 8'd2);
    step("t1_sub", 1'b1, 1, 0, 1'b0);  chk("t1_sub_ctrl", 8'(bus.alucontrol), 8'd6);
    step("t1_and", 1'b1, 3, 0, 1'b0);  chk("t1_and_ctrl", 8'(bus.alucontrol), 8'd0);
    chk("t1_valid", 8'(bus.valid_out), 8'd1);

    // T2: R-format functs and JR
    for (int i = 0; i < 7; i++) begin
      step("t2_r", 1'b1, 2, t2f[i], 1'b0);
      chk("t2_ctrl", 8'(bus.alucontrol), 8'(t2e[i]));
    end
    step("t2_jr", 1'b1, 2, 8, 1'b0);
    chk("t2_jr_flag", 8'(bus.jr), 8'd1);
    chk("t2_jr_ctrl", 8'(bus.alucontrol), 8'd2);

    // T3: illegal funct, wide aluop codes
    step("t3_badfn", 1'b1, 2, 5, 1'b0);
    chk("t3_badfn_ill", 8'(bus.illegal), 8'd1);
    chk("t3_badfn_ctrl", 8'(bus.alucontrol), 8'd2);
    step("t3_or", 1'b1, 4, 0, 1'b0);   chk("t3_or_ctrl", 8'(bus.alucontrol), 8'd1);
    step("t3_slt", 1'b1, 5, 0, 1'b0);  chk("t3_slt_ctrl", 8'(bus.alucontrol), 8'd7);
    step("t3_bad", 1'b1, 6, 0, 1'b0);  chk("t3_bad_ill", 8'(bus.illegal), 8'd1);

    // Hold on no-accept and flush priority over valid_in
    step("hold_sub", 1'b1, 1, 0, 1'b0);
    step("hold_idle", 1'b0, 0, 0, 1'b0);
    chk("hold_ctrl", 8'(bus.alucontrol), 8'd6);
    step("flush_idle", 1'b1, 0, 0, 1'b1);
    chk("flush_valid", 8'(bus.valid_out), 8'd0);

    // T4: MULT with ADD held upstream, accepted in the DONE cycle
    step("t4_mult", 1'b1, 2, 24, 1'b0);
    chk("t4_start", 8'(bus.md_start), 8'd1);
    chk("t4_stall1", 8'(bus.stall), 8'd1);
    for (int i = 0; i < MDC - 1; i++) begin
      step("t4_busy", 1'b1, 0, 0, 1'b0);
      chk("t4_stall", 8'(bus.stall), 8'd1);
    end
    step("t4_done", 1'b1, 0, 0, 1'b0);
    chk("t4_md_done", 8'(bus.md_done), 8'd1);
    chk("t4_stall_drop", 8'(bus.stall), 8'd0);
    step("t4_add", 1'b1, 0, 0, 1'b0);
    chk("t4_add_valid", 8'(bus.valid_out), 8'd1);
    chk("t4_add_ctrl", 8'(bus.alucontrol), 8'd2);

    // T5: DIV flushed in its second BUSY cycle
    step("t5_div", 1'b1, 2, 26, 1'b0);
    chk("t5_isdiv", 8'(bus.md_is_div), 8'd1);
    step("t5_busy", 1'b0, 0, 0, 1'b0);
    step("t5_flush", 1'b0, 0, 0, 1'b1);
    chk("t5_stall_drop", 8'(bus.stall), 8'd0);
    for (int i = 0; i < MDC; i++) step("t5_nodone", 1'b0, 0, 0, 1'b0);

    // Flush in the md_start cycle
    step("fs_mult", 1'b1, 2, 24, 1'b0);
    step("fs_flush", 1'b0, 0, 0, 1'b1);
    chk("fs_stall", 8'(bus.stall), 8'd0);
    step("fs_idle", 1'b0, 0, 0, 1'b0);

    // T5: async reset mid-BUSY
    step("rm_div", 1'b1, 2, 26, 1'b0);
    step("rm_busy", 1'b1, 2, 26, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;

    // T6: DIV held through DONE restarts immediately
    step("t6_div", 1'b1, 2, 26, 1'b0);
    for (int i = 0; i < MDC; i++) step("t6_busy", 1'b1, 2, 26, 1'b0);
    chk("t6_md_done", 8'(bus.md_done), 8'd1);
    step("t6_restart", 1'b1, 2, 26, 1'b0);
    chk("t6_start", 8'(bus.md_start), 8'd1);
    chk("t6_isdiv", 8'(bus.md_is_div), 8'd1);
    step("t6_flush", 1'b0, 0, 0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 9) < 8);
      fl = ($urandom_range(0, 15) == 0);
      op = ($urandom_range(0, 1) == 1) ? 2 : int'($urandom_range(0, 7));
      fn = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 63)) : ftab[$urandom_range(0, 9)];
      step("rand", v, op, fn, fl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, errs);
    $finish;
  end

endmodule
